contador_regressivo: RTL and testbench
======================================

// Module: contador_regressivo
// PURPOSE
//  Bomb countdown core. Loads an MM:SS time in BCD and counts down once per second from CLOCK.
//  Drives four BCD digits to the 7-seg decoders.
//  Asserts TEMPO_ACABOU, which feeds the explosion animation stage downstream, when 00:00 is reached.
//  Supports arm/defuse control from board keys (keys pre-debounced, one-cycle pulses).
// PARAMETERS
//  CLK_FREQ_HZ   50_000_000  CLOCK cycles per countdown second (bench uses 4)
// PORTS
//  CLOCK         in   1  system clock, single clock domain
//  RESET         in   1  asynchronous, active-high reset
//  ARMAR         in   1  1-cycle pulse: load CARGA_* and start counting
//  DESARMAR      in   1  1-cycle pulse: freeze count, bomb defused
//  CARGA_MIN_D   in   4  load value, minutes tens (BCD)
//  CARGA_MIN_U   in   4  load value, minutes units (BCD)
//  CARGA_SEG_D   in   4  load value, seconds tens (BCD)
//  CARGA_SEG_U   in   4  load value, seconds units (BCD)
//  MIN_D, MIN_U  out  4  current minutes digits (BCD)
//  SEG_D, SEG_U  out  4  current seconds digits (BCD)
//  ATIVA         out  1  high while counting
//  DESARMADA     out  1  high in DEFUSED state
//  TEMPO_ACABOU  out  1  high in EXPLODED state; sticky until RESET
//  TICK_1HZ      out  1  1-cycle pulse per elapsed second while counting (LED blink)
// BEHAVIOUR
//  Reset (async): state OCIOSO, all digits 0, all flags 0, prescaler 0.
//  FSM states: OCIOSO, CONTANDO, DESARMADA, EXPLODIU.
//  OCIOSO -> CONTANDO on ARMAR:
//   - digits <= CARGA_* next edge, prescaler cleared.
//   - Invalid load digits saturate: any digit >9 -> 9, SEG_D >5 -> 5.
//  OCIOSO + ARMAR with load 00:00 -> EXPLODIU directly, same edge.
//  CONTANDO:
//   - Prescaler counts 0..CLK_FREQ_HZ-1; at terminal count it wraps to 0 and a tick fires.
//   - First tick occurs exactly CLK_FREQ_HZ cycles after the ARMAR edge.
//   - Tick decrements MM:SS with BCD borrow:
//     SEG_U 0->9 borrows; SEG_D 0->5 borrows; MIN_U 0->9 borrows; MIN_D decrements.
//   - TICK_1HZ is registered and high for the cycle after each tick.
//   - Tick at 00:01 -> digits 00:00 and state EXPLODIU on the same edge.
//     TEMPO_ACABOU is a registered state decode, high from that edge.
//  CONTANDO + DESARMAR -> DESARMADA; digits frozen.
//   - DESARMAR wins over a simultaneous tick, including the 00:01 tick.
//  ARMAR is ignored in CONTANDO, DESARMADA and EXPLODIU.
//  DESARMAR is ignored in OCIOSO and EXPLODIU.
//  DESARMADA and EXPLODIU are terminal; only RESET leaves them.
//  Prescaler is held at 0 outside CONTANDO.
//  RESET mid-count: immediate return to reset values, no tick emitted.
//  Prescaler width is $clog2(CLK_FREQ_HZ); digits never leave the valid BCD range.
// STRUCTURE
//  Package bomba_pkg:
//   - typedef enum logic [1:0] estado_t {OCIOSO, CONTANDO, DESARMADA, EXPLODIU}
//   - typedef logic [3:0] bcd_t
//   - constants SEG_D_MAX = 5, DIG_MAX = 9
//  Sub-module divisor_tick(CLOCK, RESET, EN, TICK) with parameter CLK_FREQ_HZ:
//   - synchronous clear while EN is low
//  FSM and BCD down-counter live in this module; all outputs are registered.
// TESTING (CLK_FREQ_HZ=4)
//  1. Load 00:03, ARMAR -> SEG_U = 2, 1, 0 at +4, +8, +12 cycles; TEMPO_ACABOU=1 from +12, stays 1 for 20 more cycles.
//  2. Load 10:00, ARMAR, 1 tick -> 09:59; load 01:00, 1 tick -> 00:59 (full borrow chain).
//  3. Load 00:05, DESARMAR on the same cycle as the 00:01 tick -> DESARMADA=1, digits 00:01, TEMPO_ACABOU=0.
//  4. Load 00:00, ARMAR -> TEMPO_ACABOU=1 next edge, ATIVA never high, TICK_1HZ never pulses.
//  5. Load F:7 digits (MIN_U=F, SEG_D=7) -> loaded as 9 and 5; a second ARMAR while counting is ignored.
//  6. RESET asserted mid-count (async, between edges) -> outputs 0 immediately; a following ARMAR restarts cleanly.

Source files
------------

// File: rtl/contador_regressivo_pkg.sv
// Package bomba_pkg: shared types and constants for the bomb countdown core.
//   estado_t  : FSM states (OCIOSO, CONTANDO, DESARMADA, EXPLODIU)
//   bcd_t     : one BCD digit
//   SEG_D_MAX : largest legal seconds-tens digit
//   DIG_MAX   : largest legal BCD digit
//   satura()  : clamps a load digit to its legal maximum
package bomba_pkg;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    CONTANDO  = 2'd1,
    DESARMADA = 2'd2,
    EXPLODIU  = 2'd3
  } estado_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t SEG_D_MAX = 4'd5;
  localparam bcd_t DIG_MAX   = 4'd9;

  // Out-of-range load digits are clamped so the display never shows a non-BCD value.
  function automatic bcd_t satura(input bcd_t valor, input bcd_t limite);
    return (valor > limite) ? limite : valor;
  endfunction

endpackage

// File: rtl/contador_regressivo_if.sv
// Interface contador_regressivo_if: groups the control/load inputs and the
// display/status outputs of the countdown core.
//   ARMAR, DESARMAR            : one-cycle key pulses (master -> slave)
//   CARGA_MIN_D..CARGA_SEG_U   : MM:SS load value in BCD (master -> slave)
//   MIN_D..SEG_U               : current MM:SS digits in BCD (slave -> master)
//   ATIVA, DESARMADA           : counting / defused status (slave -> master)
//   TEMPO_ACABOU               : exploded, sticky until RESET (slave -> master)
//   TICK_1HZ                   : one-cycle pulse per elapsed second (slave -> master)
// The slave modport is used by the core; the master modport by whatever drives it.
interface contador_regressivo_if;

  logic            ARMAR;
  logic            DESARMAR;
  bomba_pkg::bcd_t CARGA_MIN_D;
  bomba_pkg::bcd_t CARGA_MIN_U;
  bomba_pkg::bcd_t CARGA_SEG_D;
  bomba_pkg::bcd_t CARGA_SEG_U;
  bomba_pkg::bcd_t MIN_D;
  bomba_pkg::bcd_t MIN_U;
  bomba_pkg::bcd_t SEG_D;
  bomba_pkg::bcd_t SEG_U;
  logic            ATIVA;
  logic            DESARMADA;
  logic            TEMPO_ACABOU;
  logic            TICK_1HZ;

  modport master (
    output ARMAR, DESARMAR, CARGA_MIN_D, CARGA_MIN_U, CARGA_SEG_D, CARGA_SEG_U,
    input  MIN_D, MIN_U, SEG_D, SEG_U, ATIVA, DESARMADA, TEMPO_ACABOU, TICK_1HZ
  );

  modport slave (
    input  ARMAR, DESARMAR, CARGA_MIN_D, CARGA_MIN_U, CARGA_SEG_D, CARGA_SEG_U,
    output MIN_D, MIN_U, SEG_D, SEG_U, ATIVA, DESARMADA, TEMPO_ACABOU, TICK_1HZ
  );

endinterface

// File: rtl/contador_regressivo_divisor.sv
// Module divisor_tick: prescaler that turns CLOCK into one tick per second.
//   CLOCK : system clock
//   RESET : asynchronous, active-high reset
//   EN    : count enable; the count is synchronously cleared while low
//   TICK  : high during the last cycle of each CLK_FREQ_HZ-cycle period,
//           so the consumer acts on the edge where the count wraps
module divisor_tick #(
  parameter int CLK_FREQ_HZ = 50_000_000
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic EN,
  output logic TICK
);

  localparam int LARGURA = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [LARGURA-1:0] TERMINAL = LARGURA'(CLK_FREQ_HZ - 1);

  logic [LARGURA-1:0] contagem;

  // Count 0..CLK_FREQ_HZ-1 while enabled; clearing while disabled means the
  // first period after enabling is always a full second long.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      contagem <= '0;
    end else if (!EN) begin
      contagem <= '0;
    end else if (contagem == TERMINAL) begin
      contagem <= '0;
    end else begin
      contagem <= contagem + LARGURA'(1);
    end
  end

  assign TICK = EN && (contagem == TERMINAL);

endmodule

// File: rtl/contador_regressivo.sv
// Module contador_regressivo: bomb countdown core.
//   CLOCK : system clock, single domain
//   RESET : asynchronous, active-high reset
//   bus   : contador_regressivo_if.slave (keys, MM:SS load, digits, status flags)
// Loads an MM:SS value on ARMAR, counts down once per CLK_FREQ_HZ cycles with
// BCD borrow, freezes on DESARMAR and flags TEMPO_ACABOU when 00:00 is reached.
// Digits, state and TICK_1HZ are all held in registers.
module contador_regressivo
  import bomba_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  contador_regressivo_if.slave  bus
);

  estado_t estado, estado_prox;
  bcd_t    min_d, min_u, seg_d, seg_u;
  bcd_t    min_d_prox, min_u_prox, seg_d_prox, seg_u_prox;
  logic    tick_1hz, tick_1hz_prox;
  logic    tick;
  logic    contando;

  bcd_t    carga_min_d, carga_min_u, carga_seg_d, carga_seg_u;
  logic    carga_zero;
  logic    ultimo_segundo;

  assign contando = (estado == CONTANDO);

  divisor_tick #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_divisor (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .EN    (contando),
    .TICK  (tick)
  );

  assign carga_min_d = satura(bus.CARGA_MIN_D, DIG_MAX);
  assign carga_min_u = satura(bus.CARGA_MIN_U, DIG_MAX);
  assign carga_seg_d = satura(bus.CARGA_SEG_D, SEG_D_MAX);
  assign carga_seg_u = satura(bus.CARGA_SEG_U, DIG_MAX);

  // A zero load never enters CONTANDO: it explodes on the arming edge itself.
  assign carga_zero = (carga_min_d == 4'd0) && (carga_min_u == 4'd0) &&
                      (carga_seg_d == 4'd0) && (carga_seg_u == 4'd0);

  assign ultimo_segundo = (min_d == 4'd0) && (min_u == 4'd0) &&
                          (seg_d == 4'd0) && (seg_u == 4'd1);

  // Next-state and next-digit logic. DESARMAR is checked before the tick so a
  // defuse always beats a simultaneous second, including the final one. Since
  // 00:01 goes straight to EXPLODIU, CONTANDO never sees 00:00 and the minutes
  // tens digit cannot underflow.
  always_comb begin
    estado_prox   = estado;
    min_d_prox    = min_d;
    min_u_prox    = min_u;
    seg_d_prox    = seg_d;
    seg_u_prox    = seg_u;
    tick_1hz_prox = 1'b0;

    case (estado)
      OCIOSO: begin
        if (bus.ARMAR) begin
          min_d_prox  = carga_min_d;
          min_u_prox  = carga_min_u;
          seg_d_prox  = carga_seg_d;
          seg_u_prox  = carga_seg_u;
          estado_prox = carga_zero ? EXPLODIU : CONTANDO;
        end
      end

      CONTANDO: begin
        if (bus.DESARMAR) begin
          estado_prox = DESARMADA;
        end else if (tick) begin
          tick_1hz_prox = 1'b1;
          if (seg_u != 4'd0) begin
            seg_u_prox = seg_u - 4'd1;
          end else begin
            seg_u_prox = DIG_MAX;
            if (seg_d != 4'd0) begin
              seg_d_prox = seg_d - 4'd1;
            end else begin
              seg_d_prox = SEG_D_MAX;
              if (min_u != 4'd0) begin
                min_u_prox = min_u - 4'd1;
              end else begin
                min_u_prox = DIG_MAX;
                min_d_prox = min_d - 4'd1;
              end
            end
          end
          if (ultimo_segundo) begin
            estado_prox = EXPLODIU;
          end
        end
      end

      default: begin
      end
    endcase
  end

  // State, digit and tick-pulse registers.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      estado   <= OCIOSO;
      min_d    <= 4'd0;
      min_u    <= 4'd0;
      seg_d    <= 4'd0;
      seg_u    <= 4'd0;
      tick_1hz <= 1'b0;
    end else begin
      estado   <= estado_prox;
      min_d    <= min_d_prox;
      min_u    <= min_u_prox;
      seg_d    <= seg_d_prox;
      seg_u    <= seg_u_prox;
      tick_1hz <= tick_1hz_prox;
    end
  end

  assign bus.MIN_D        = min_d;
  assign bus.MIN_U        = min_u;
  assign bus.SEG_D        = seg_d;
  assign bus.SEG_U        = seg_u;
  assign bus.ATIVA        = (estado == CONTANDO);
  assign bus.DESARMADA    = (estado == DESARMADA);
  assign bus.TEMPO_ACABOU = (estado == EXPLODIU);
  assign bus.TICK_1HZ     = tick_1hz;

endmodule

// File: tb/tb_contador_regressivo.sv
// Testbench for contador_regressivo with CLK_FREQ_HZ = 4.
// The reference model keeps the remaining time as a plain number of seconds
// and derives the expected BCD digits by division, independent of the RTL's
// digit-wise borrow chain.
module tb_contador_regressivo;
  import bomba_pkg::*;

  localparam int FREQ = 4;

  localparam int M_OCIOSO    = 0;
  localparam int M_CONTANDO  = 1;
  localparam int M_DESARMADA = 2;
  localparam int M_EXPLODIU  = 3;

  logic CLOCK = 1'b0;
  logic RESET;

  always #5 CLOCK = ~CLOCK;

  contador_regressivo_if bus();

  contador_regressivo #(
    .CLK_FREQ_HZ(FREQ)
  ) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus)
  );

  int   compared   = 0;
  int   mismatched = 0;

  int   m_estado;
  int   m_segundos;
  int   m_ciclos;
  logic m_tick;

  // Behavioural reference: remaining time in seconds, cycles elapsed in the current second.
  task automatic model_reset();
    m_estado   = M_OCIOSO;
    m_segundos = 0;
    m_ciclos   = 0;
    m_tick     = 1'b0;
  endtask

  task automatic model_step(input logic a, input logic d,
                            input bcd_t cmd, input bcd_t cmu, input bcd_t csd, input bcd_t csu);
    int md, mu, sd, su;
    m_tick = 1'b0;
    case (m_estado)
      M_OCIOSO: begin
        if (a) begin
          md = (int'(cmd) > 9) ? 9 : int'(cmd);
          mu = (int'(cmu) > 9) ? 9 : int'(cmu);
          sd = (int'(csd) > 5) ? 5 : int'(csd);
          su = (int'(csu) > 9) ? 9 : int'(csu);
          m_segundos = (md * 10 + mu) * 60 + sd * 10 + su;
          m_ciclos   = 0;
          m_estado   = (m_segundos == 0) ? M_EXPLODIU : M_CONTANDO;
        end
      end
      M_CONTANDO: begin
        if (d) begin
          m_estado = M_DESARMADA;
        end else begin
          m_ciclos++;
          if (m_ciclos == FREQ) begin
            m_ciclos = 0;
            m_segundos--;
            m_tick = 1'b1;
            if (m_segundos == 0) m_estado = M_EXPLODIU;
          end
        end
      end
      default: begin
      end
    endcase
  endtask

  task automatic checkOutput(input string tag);
    logic [19:0] obs, esp;
    obs = {bus.MIN_D, bus.MIN_U, bus.SEG_D, bus.SEG_U,
           bus.ATIVA, bus.DESARMADA, bus.TEMPO_ACABOU, bus.TICK_1HZ};
    esp = {4'(m_segundos / 600), 4'((m_segundos / 60) % 10),
           4'((m_segundos % 60) / 10), 4'(m_segundos % 10),
           m_estado == M_CONTANDO, m_estado == M_DESARMADA,
           m_estado == M_EXPLODIU, m_tick};
    compared++;
    assert (obs === esp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h (MMSS,ativa,desarm,acabou,tick)", tag, obs, esp);
    end
  endtask

  // One clock cycle: drive at the falling edge, model at the rising edge, check at the next falling edge.
  task automatic applyStimulus(input logic a, input logic d,
                               input bcd_t cmd, input bcd_t cmu, input bcd_t csd, input bcd_t csu,
                               input string tag);
    bus.ARMAR       = a;
    bus.DESARMAR    = d;
    bus.CARGA_MIN_D = cmd;
    bus.CARGA_MIN_U = cmu;
    bus.CARGA_SEG_D = csd;
    bus.CARGA_SEG_U = csu;
    @(posedge CLOCK);
    model_step(a, d, cmd, cmu, csd, csu);
    #1;
    bus.ARMAR    = 1'b0;
    bus.DESARMAR = 1'b0;
    @(negedge CLOCK);
    checkOutput(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, tag);
  endtask

  // Asynchronous reset asserted between edges and checked before any clock edge.
  task automatic do_reset(input string tag);
    #2;
    RESET = 1'b1;
    model_reset();
    #1;
    checkOutput(tag);
    @(negedge CLOCK);
    RESET = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RESET           = 1'b1;
    bus.ARMAR       = 1'b0;
    bus.DESARMAR    = 1'b0;
    bus.CARGA_MIN_D = 4'd0;
    bus.CARGA_MIN_U = 4'd0;
    bus.CARGA_SEG_D = 4'd0;
    bus.CARGA_SEG_U = 4'd0;
    model_reset();
    repeat (2) @(negedge CLOCK);
    checkOutput("reset_state");
    RESET = 1'b0;

    // 1: 00:03 counts down to 00:00 and stays exploded; keys ignored afterwards
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd3, "t1_arm");
    idle(12, "t1_count");
    idle(20, "t1_exploded_hold");
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd5, "t1_arm_exploded");
    applyStimulus(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, "t1_desarm_exploded");
    idle(5, "t1_after_keys");

    // 2: full borrow chain
    do_reset("t2_reset_a");
    applyStimulus(1'b1, 1'b0, 4'd1, 4'd0, 4'd0, 4'd0, "t2_arm_1000");
    idle(4, "t2_0959");
    do_reset("t2_reset_b");
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd1, 4'd0, 4'd0, "t2_arm_0100");
    idle(4, "t2_0059");

    // 3: defuse on the same cycle as the 00:01 tick
    do_reset("t3_reset");
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd5, "t3_arm");
    idle(19, "t3_count");
    applyStimulus(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, "t3_defuse");
    idle(8, "t3_defused_hold");
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd5, "t3_arm_defused");

    // 4: zero load explodes immediately
    do_reset("t4_reset");
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, "t4_arm_zero");
    idle(8, "t4_hold");

    // 5: saturation of invalid digits, DESARMAR ignored idle, second ARMAR ignored
    do_reset("t5_reset");
    applyStimulus(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, "t5_desarm_idle");
    applyStimulus(1'b1, 1'b0, 4'd0, 4'hF, 4'd7, 4'd3, "t5_arm_sat");
    idle(3, "t5_count");
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd1, "t5_rearm");
    idle(6, "t5_after_rearm");

    // 6: asynchronous reset mid-count, then clean restart
    do_reset("t6_reset_a");
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd9, "t6_arm");
    idle(6, "t6_count");
    do_reset("t6_reset_mid");
    idle(2, "t6_idle");
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd2, "t6_rearm");
    idle(10, "t6_recount");

    // Randomized sessions
    for (int s = 0; s < 12; s++) begin
      bcd_t rmd, rmu, rsd, rsu;
      do_reset("rnd_reset");
      rmd = 4'($urandom_range(0, 15));
      rmu = 4'($urandom_range(0, 15));
      rsd = 4'($urandom_range(0, 15));
      rsu = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        rmd = 4'd0;
        rmu = 4'd0;
        rsd = 4'd0;
      end
      applyStimulus(1'b1, 1'b0, rmd, rmu, rsd, rsu, "rnd_arm");
      for (int c = 0; c < int'($urandom_range(10, 50)); c++) begin
        applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 40) == 0,
                      4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "rnd_run");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
